i2c_target_regs: RTL and testbench
==================================

Name: i2c_target_regs

Overview:
- Synthesizable, parametrised I2C target (slave) with a byte-wide register file, auto-incrementing register pointer and open-drain SDA control.
- Replaces the behavioural slave tasks used in top-level benches; sits beside the I2C master inside top and drives leds from its register outputs.
- Supports write, read, repeated START, address filtering, pointer wrap and out-of-range handling.

Parameters:
- TARGET_ADDR, 7'h50, 7-bit I2C address this block responds to.
- NUM_REGS, 4, number of 8-bit registers; legal range 1..256.
- SYNC_STAGES, 2, synchroniser flops on scl_i/sda_i; minimum 2.

Ports:
- clk  input  1  system clock; must be at least 8x the SCL frequency.
- rst  input  1  asynchronous, active-low reset.
- scl_i  input  1  SCL line level.
- sda_i  input  1  SDA line level.
- sda_oe  output  1  1 = pull SDA low, 0 = release (open-drain).
- regs_o  output  NUM_REGS*8  flattened register file; reg k is at [8k+7:8k].
- wr_strobe  output  1  one-cycle pulse when a register is written.
- wr_addr  output  8  pointer value of the register written; valid with wr_strobe.
- busy  output  1  high from an address-matched START until STOP.

Behaviour:
- Reset (rst=0, async):
  - sda_oe=0, regs_o=0, wr_strobe=0, wr_addr=0, busy=0.
  - Pointer=0, state=IDLE, synchronisers set to 1.
- Sync and edge detection:
  - scl/sda pass through SYNC_STAGES flops, followed by one history flop.
  - SCL rise/fall and SDA rise/fall are detected from the synced level versus the history flop.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high.
- Priority:
  - START/STOP are detected in every state and take priority over bit handling in the same cycle.
  - START (including repeated) -> ADDR with bit count 0 and sda_oe=0.
  - STOP -> IDLE with sda_oe=0 and busy=0. A partial byte is discarded with no write.
- Bit handling:
  - Bits are sampled on SCL rise, MSB first.
  - sda_oe changes only on SCL fall, except on reset, START or STOP.
- ACK slot:
  - After the 8th bit is sampled, the next SCL fall sets sda_oe=1.
  - The following SCL fall clears sda_oe.
- State machine:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - If addr[7:1]==TARGET_ADDR: busy=1, ACK, then go to PTR if R/W=0, or RDATA if R/W=1.
    - If addr[7:1] differs: no ACK -> IGNORE.
  - IGNORE: sda_oe=0; leave only on START/STOP.
  - PTR: shift 8 bits and ACK. Pointer is loaded with the byte at the 8th rise. Any value is ACKed, including out-of-range values. Then go to WDATA.
  - WDATA: shift 8 bits; at the 8th rise:
    - If pointer<NUM_REGS: the register is written, and next cycle wr_strobe=1 with wr_addr=pointer.
    - If pointer>=NUM_REGS: data is discarded and there is no strobe.
    - Either way the byte is ACKed and the pointer increments. Stay in WDATA.
  - RDATA:
    - The byte is loaded at the SCL fall that ends the address ACK, or the master ACK. It is reg[pointer], or 8'hFF if pointer>=NUM_REGS.
    - Each SCL fall drives sda_oe = ~bit, MSB first.
    - After 8 bits, the next fall releases SDA (sda_oe=0) and the master ACK is sampled on the next rise:
      - 0 (ACK): pointer increments; the next byte loads on the following fall.
      - 1 (NACK): go to IGNORE with SDA released.
- Pointer increment: pointer==NUM_REGS-1 -> 0; otherwise pointer+1 modulo 256.
- Pointer persistence: the pointer persists across transactions, so a write of only the pointer sets the read start.
- Write timing: a register write and a STOP in the same cycle never coincide, because the 8th rise precedes any STOP edge.
- Outputs: regs_o is registered and changes only on writes or reset.

Test Plan:
- Write burst:
  - Stimulus: START, 0xA0, ptr 0x01, 0x3C, 0x5A, STOP.
  - Response: 4 ACK slots with sda_oe=1. regs[1]=0x3C, regs[2]=0x5A. wr_strobe pulses twice with wr_addr 1 then 2. busy returns to 0 after STOP.
- Read via repeated START:
  - Stimulus: START, 0xA0, 0x01, Sr, 0xA1, master ACK, master NACK, STOP.
  - Response: SDA carries 0x3C then 0x5A. sda_oe=0 after the NACK. No wr_strobe.
- Wrong address:
  - Stimulus: START, 0x84, 0x00, 0x77, STOP.
  - Response: no ACK (sda_oe stays 0 throughout), busy=0, regs unchanged.
- Wrap and out-of-range:
  - Stimulus: write ptr 0x03 with data 0x11, 0x22. Then write ptr 0x09 with 0xEE, and read at ptr 0x09.
  - Response: regs[3]=0x11 and regs[0]=0x22. The 0xEE byte is ACKed with no strobe. The read returns 0xFF.
- STOP mid-byte:
  - Stimulus: write ptr 0x00, send 4 data bits, then STOP.
  - Response: regs[0] unchanged, no strobe, state returns to IDLE.
- Reset mid-transaction:
  - Stimulus: assert rst during WDATA while sda_oe=1.
  - Response: sda_oe=0 and regs_o=0 immediately. After release, a full write of 0x3C to ptr 0x01 succeeds.

Source files
------------

// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target with an auto-incrementing byte register file
//   clk       system clock, at least 8x SCL
//   rst       asynchronous active-low reset
//   scl_i     SCL line level
//   sda_i     SDA line level
//   sda_oe    1 pulls SDA low (open-drain)
//   regs_o    flattened registers, reg k at [8k+7:8k]
//   wr_strobe one-cycle pulse per register write
//   wr_addr   pointer of the written register, valid with wr_strobe
//   busy      high from an address-matched START until STOP
module i2c_target_regs #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         NUM_REGS    = 4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  output logic [NUM_REGS*8-1:0] regs_o,
  output logic                  wr_strobe,
  output logic [7:0]            wr_addr,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_IGNORE,
    S_PTR,
    S_WDATA,
    S_RDATA
  } state_t;

  localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);
  localparam logic [7:0] LAST_PTR   = 8'(NUM_REGS - 1);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_hist_q, scl_hist_d;
  logic                   sda_hist_q, sda_hist_d;
  state_t                 state_q, state_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             rx_q, rx_d;
  logic [7:0]             tx_q, tx_d;
  logic [7:0]             ptr_q, ptr_d;
  logic                   rw_q, rw_d;
  logic                   sda_oe_q, sda_oe_d;
  logic [NUM_REGS*8-1:0]  regs_q, regs_d;
  logic                   wr_strobe_q, wr_strobe_d;
  logic [7:0]             wr_addr_q, wr_addr_d;
  logic                   busy_q, busy_d;

  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall, sda_rise, sda_fall;
  logic       start_det, stop_det;
  logic [7:0] rx_byte;
  logic [7:0] rd_byte;
  logic [7:0] ptr_inc;
  logic       ptr_in_range;

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s & scl_hist_q;
  assign sda_rise  = sda_s & ~sda_hist_q;
  assign sda_fall  = ~sda_s & sda_hist_q;
  assign start_det = sda_fall & scl_s;
  assign stop_det  = sda_rise & scl_s;

  // Completed byte as it stands at the 8th SCL rise.
  assign rx_byte      = {rx_q[6:0], sda_s};
  assign ptr_in_range = {1'b0, ptr_q} < NUM_REGS_W;
  assign ptr_inc      = (ptr_q == LAST_PTR) ? 8'd0 : ptr_q + 8'd1;

  // Out-of-range reads return all ones.
  always_comb begin
    rd_byte = 8'hFF;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (ptr_q == 8'(k)) rd_byte = regs_q[k*8 +: 8];
    end
  end

  // bit_cnt: 0..7 bits in flight, 8 = byte complete (ACK goes out on next
  // fall), 9 = ACK slot / master ACK pending, 10 = next read byte pending.
  always_comb begin
    scl_sync_d  = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
    sda_sync_d  = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    scl_hist_d  = scl_s;
    sda_hist_d  = sda_s;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    busy_d      = busy_q;

    if (start_det) begin
      state_d   = S_ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = S_IDLE;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            rx_d      = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (state_q == S_ADDR) begin
                if (rx_byte[7:1] == TARGET_ADDR) begin
                  busy_d = 1'b1;
                  rw_d   = rx_byte[0];
                end else begin
                  state_d = S_IGNORE;
                end
              end else if (state_q == S_PTR) begin
                ptr_d = rx_byte;
              end else begin
                if (ptr_in_range) begin
                  for (int k = 0; k < NUM_REGS; k++) begin
                    if (ptr_q == 8'(k)) regs_d[k*8 +: 8] = rx_byte;
                  end
                  wr_strobe_d = 1'b1;
                  wr_addr_d   = ptr_q;
                end
                ptr_d = ptr_inc;
              end
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_oe_d  = 1'b1;
            bit_cnt_d = 4'd9;
          end else if (scl_fall && bit_cnt_q == 4'd9) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            if (state_q == S_ADDR) begin
              if (rw_q) begin
                // The fall that ends the address ACK also presents the MSB.
                state_d   = S_RDATA;
                tx_d      = {rd_byte[6:0], 1'b0};
                sda_oe_d  = ~rd_byte[7];
                bit_cnt_d = 4'd1;
              end else begin
                state_d = S_PTR;
              end
            end else begin
              state_d = S_WDATA;
            end
          end
        end
        S_RDATA: begin
          if (scl_fall) begin
            if (bit_cnt_q < 4'd8) begin
              sda_oe_d  = ~tx_q[7];
              tx_d      = {tx_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end else if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd9;
            end else if (bit_cnt_q == 4'd10) begin
              tx_d      = {rd_byte[6:0], 1'b0};
              sda_oe_d  = ~rd_byte[7];
              bit_cnt_d = 4'd1;
            end
          end else if (scl_rise && bit_cnt_q == 4'd9) begin
            if (!sda_s) begin
              ptr_d     = ptr_inc;
              bit_cnt_d = 4'd10;
            end else begin
              state_d  = S_IGNORE;
              sda_oe_d = 1'b0;
            end
          end
        end
        S_IGNORE: sda_oe_d = 1'b0;
        S_IDLE:   sda_oe_d = 1'b0;
        default:  state_d  = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      scl_hist_q  <= 1'b1;
      sda_hist_q  <= 1'b1;
      state_q     <= S_IDLE;
      bit_cnt_q   <= 4'd0;
      rx_q        <= 8'd0;
      tx_q        <= 8'd0;
      ptr_q       <= 8'd0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      regs_q      <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 8'd0;
      busy_q      <= 1'b0;
    end else begin
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      scl_hist_q  <= scl_hist_d;
      sda_hist_q  <= sda_hist_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      busy_q      <= busy_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign regs_o    = regs_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb/tb_i2c_target_regs.sv - bus-level bench for i2c_target_regs against a register-file model
module tb_i2c_target_regs;

  localparam int         NUM_REGS = 4;
  localparam logic [6:0] TADDR    = 7'h50;
  localparam int         Q        = 5;
  localparam logic [7:0] ADDR_W   = {TADDR, 1'b0};
  localparam logic [7:0] ADDR_R   = {TADDR, 1'b1};

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  scl = 1'b1;
  logic                  sda_m = 1'b1;
  logic                  sda_line;
  logic                  sda_oe;
  logic [NUM_REGS*8-1:0] regs_o;
  logic                  wr_strobe;
  logic [7:0]            wr_addr;
  logic                  busy;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_regs [NUM_REGS];
  int         m_ptr;
  int         exp_strobe [$];
  logic [7:0] strobe_q [$];
  logic [7:0] wbuf [4];
  logic [7:0] rbuf [4];
  logic       oe_seen;

  assign sda_line = sda_m & ~sda_oe;

  i2c_target_regs #(
    .TARGET_ADDR(TADDR),
    .NUM_REGS   (NUM_REGS),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl),
    .sda_i    (sda_line),
    .sda_oe   (sda_oe),
    .regs_o   (regs_o),
    .wr_strobe(wr_strobe),
    .wr_addr  (wr_addr),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst && wr_strobe) strobe_q.push_back(wr_addr);
    if (sda_oe) oe_seen = 1'b1;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  function automatic logic [NUM_REGS*8-1:0] model_flat();
    logic [NUM_REGS*8-1:0] r;
    for (int k = 0; k < NUM_REGS; k++) r[k*8 +: 8] = m_regs[k];
    return r;
  endfunction

  function automatic int next_ptr(input int p);
    return (p == NUM_REGS - 1) ? 0 : (p + 1) % 256;
  endfunction

  task automatic model_write(input logic [7:0] b);
    if (m_ptr < NUM_REGS) begin
      m_regs[m_ptr] = b;
      exp_strobe.push_back(m_ptr);
    end
    m_ptr = next_ptr(m_ptr);
  endtask

  task automatic start_cond();
    sda_m = 1'b1; wait_q();
    scl = 1'b1;   wait_q();
    sda_m = 1'b0; wait_q();
    scl = 1'b0;   wait_q();
  endtask

  task automatic stop_cond();
    sda_m = 1'b0; wait_q();
    scl = 1'b1;   wait_q();
    sda_m = 1'b1; wait_q();
    wait_q();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_m = b[i]; wait_q();
      scl = 1'b1;   wait_q(); wait_q();
      scl = 1'b0;   wait_q();
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    sda_m = 1'b1; wait_q();
    scl = 1'b1;   wait_q();
    ack = sda_oe;
    wait_q();
    scl = 1'b0;   wait_q();
  endtask

  task automatic read_byte(output logic [7:0] b, input logic nack);
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      sda_m = 1'b1; wait_q();
      scl = 1'b1;   wait_q();
      b = {b[6:0], sda_line};
      wait_q();
      scl = 1'b0;   wait_q();
    end
    sda_m = nack; wait_q();
    scl = 1'b1;   wait_q(); wait_q();
    scl = 1'b0;   wait_q();
  endtask

  task automatic check_strobes(input string tag);
    check({tag, "_strobe_count"}, 64'(strobe_q.size()), 64'(exp_strobe.size()));
    for (int i = 0; i < exp_strobe.size() && i < strobe_q.size(); i++)
      check({tag, "_strobe_addr"}, 64'(strobe_q[i]), 64'(exp_strobe[i]));
    strobe_q.delete();
    exp_strobe.delete();
  endtask

  task automatic write_txn(input string tag, input logic [7:0] p, input int n);
    logic ack;
    start_cond();
    write_byte(ADDR_W, ack); check({tag, "_addr_ack"}, 64'(ack), 64'd1);
    write_byte(p, ack);      check({tag, "_ptr_ack"}, 64'(ack), 64'd1);
    m_ptr = int'(p);
    for (int i = 0; i < n; i++) begin
      write_byte(wbuf[i], ack);
      check({tag, "_data_ack"}, 64'(ack), 64'd1);
      model_write(wbuf[i]);
    end
    check({tag, "_busy_in"}, 64'(busy), 64'd1);
    stop_cond();
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    check({tag, "_regs"}, 64'(regs_o), 64'(model_flat()));
    check_strobes(tag);
  endtask

  task automatic read_txn(input string tag, input logic [7:0] p, input int n);
    logic ack;
    logic [7:0] b;
    start_cond();
    write_byte(ADDR_W, ack); check({tag, "_addr_ack"}, 64'(ack), 64'd1);
    write_byte(p, ack);      check({tag, "_ptr_ack"}, 64'(ack), 64'd1);
    m_ptr = int'(p);
    start_cond();
    write_byte(ADDR_R, ack); check({tag, "_raddr_ack"}, 64'(ack), 64'd1);
    for (int i = 0; i < n; i++) begin
      read_byte(b, (i == n - 1));
      rbuf[i] = b;
      check({tag, "_rdata"}, 64'(b), (m_ptr < NUM_REGS) ? 64'(m_regs[m_ptr]) : 64'hFF);
      if (i != n - 1) m_ptr = next_ptr(m_ptr);
    end
    check({tag, "_oe_after_nack"}, 64'(sda_oe), 64'd0);
    stop_cond();
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    check_strobes(tag);
  endtask

  initial begin
    logic ack;
    for (int k = 0; k < NUM_REGS; k++) m_regs[k] = 8'h00;
    m_ptr = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_sda_oe", 64'(sda_oe), 64'd0);
    check("rst_regs", 64'(regs_o), 64'd0);
    check("rst_wr_strobe", 64'(wr_strobe), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b1;
    wait_q();

    // Write burst
    wbuf[0] = 8'h3C; wbuf[1] = 8'h5A;
    exp_strobe.delete(); strobe_q.delete();
    start_cond();
    write_byte(ADDR_W, ack); check("wb_addr_ack", 64'(ack), 64'd1);
    write_byte(8'h01, ack);  check("wb_ptr_ack", 64'(ack), 64'd1);
    write_byte(8'h3C, ack);  check("wb_d0_ack", 64'(ack), 64'd1);
    write_byte(8'h5A, ack);  check("wb_d1_ack", 64'(ack), 64'd1);
    check("wb_busy_in", 64'(busy), 64'd1);
    stop_cond();
    check("wb_busy_after", 64'(busy), 64'd0);
    m_regs[1] = 8'h3C; m_regs[2] = 8'h5A; m_ptr = 3;
    check("wb_reg1", 64'(regs_o[15:8]), 64'h3C);
    check("wb_reg2", 64'(regs_o[23:16]), 64'h5A);
    exp_strobe.push_back(1); exp_strobe.push_back(2);
    check_strobes("wb");

    // Read via repeated START
    read_txn("rd", 8'h01, 2);
    check("rd_byte0", 64'(rbuf[0]), 64'h3C);
    check("rd_byte1", 64'(rbuf[1]), 64'h5A);

    // Wrong address
    oe_seen = 1'b0;
    start_cond();
    write_byte(8'h84, ack); check("wa_addr_ack", 64'(ack), 64'd0);
    write_byte(8'h00, ack); check("wa_b1_ack", 64'(ack), 64'd0);
    write_byte(8'h77, ack); check("wa_b2_ack", 64'(ack), 64'd0);
    check("wa_busy", 64'(busy), 64'd0);
    stop_cond();
    check("wa_oe_never", 64'(oe_seen), 64'd0);
    check("wa_regs", 64'(regs_o), 64'(model_flat()));
    check_strobes("wa");

    // Wrap and out-of-range
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    write_txn("wrap", 8'h03, 2);
    check("wrap_reg3", 64'(regs_o[31:24]), 64'h11);
    check("wrap_reg0", 64'(regs_o[7:0]), 64'h22);
    wbuf[0] = 8'hEE;
    write_txn("oor_wr", 8'h09, 1);
    read_txn("oor_rd", 8'h09, 1);
    check("oor_rd_ff", 64'(rbuf[0]), 64'hFF);

    // STOP mid-byte
    start_cond();
    write_byte(ADDR_W, ack); check("mid_addr_ack", 64'(ack), 64'd1);
    write_byte(8'h00, ack);  check("mid_ptr_ack", 64'(ack), 64'd1);
    m_ptr = 0;
    send_bits(8'hA5, 4);
    stop_cond();
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_reg0", 64'(regs_o[7:0]), 64'h22);
    check("mid_regs", 64'(regs_o), 64'(model_flat()));
    check_strobes("mid");
    // The target must be back in IDLE and accept a fresh read at the same pointer.
    read_txn("mid_rd", 8'h00, 1);

    // Randomized transactions
    for (int it = 0; it < 8; it++) begin
      logic [7:0] p;
      int n;
      p = 8'($urandom_range(0, 5));
      n = int'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
        write_txn("rnd_wr", p, n);
      end else begin
        read_txn("rnd_rd", p, n);
      end
    end

    // Reset mid-transaction
    start_cond();
    write_byte(ADDR_W, ack); check("rm_addr_ack", 64'(ack), 64'd1);
    write_byte(8'h02, ack);  check("rm_ptr_ack", 64'(ack), 64'd1);
    send_bits(8'h99, 8);
    check("rm_oe_before", 64'(sda_oe), 64'd1);
    rst = 1'b0;
    #1;
    check("rm_oe_reset", 64'(sda_oe), 64'd0);
    check("rm_regs_reset", 64'(regs_o), 64'd0);
    check("rm_busy_reset", 64'(busy), 64'd0);
    for (int k = 0; k < NUM_REGS; k++) m_regs[k] = 8'h00;
    m_ptr = 0;
    scl = 1'b1; sda_m = 1'b1;
    wait_q();
    strobe_q.delete(); exp_strobe.delete();
    rst = 1'b1;
    wait_q();
    wbuf[0] = 8'h3C;
    write_txn("rm_after", 8'h01, 1);
    check("rm_after_reg1", 64'(regs_o[15:8]), 64'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
